keypad_time_loader: RTL

//  Upstream feeder for the BCD countdown chain (min_ones mod10, sec_tens mod6, sec_ones mod10).

---
 rtl/keypad_time_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_time_loader.sv
// Debounces a 10-key keypad, shifts digits into an M:SS entry register and loads the BCD countdown chain on start.
// Digit appears DEBOUNCE+1 edges after a clean press; loadn pulses low the edge after start; all outputs registered.
module keypad_time_loader #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [9:0] key,
    input  logic       start,
    input  logic       clear,
    input  logic       timer_zero,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic [1:0] digit_cnt,
    output logic       locked
);
    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE);

    typedef enum logic [1:0] {DB_ARM, DB_STABLE, DB_RELEASE} db_state_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_LOADED} st_t;

    db_state_t  db_state_q, db_state_d;
    logic [3:0] db_cnt_q, db_cnt_d;
    logic [9:0] db_code_q, db_code_d;
    logic       key_evt_q, key_evt_d;
    logic [3:0] key_dig_q, key_dig_d;

    st_t        state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [1:0] cnt_q, cnt_d;
    logic       loadn_q, loadn_d;
    logic       locked_q, locked_d;

    logic       key_onehot;
    logic [3:0] key_index;
    logic       accept;

    always_comb begin
        key_onehot = (key != 10'd0) && ((key & (key - 10'd1)) == 10'd0);
        key_index  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key[i]) key_index = 4'(i);
        end
    end

    // Debouncer: a key must stay the same one-hot code for DB_LIMIT edges, then be released before the next.
    always_comb begin
        db_state_d = db_state_q;
        db_cnt_d   = db_cnt_q;
        db_code_d  = db_code_q;
        key_evt_d  = 1'b0;
        key_dig_d  = key_dig_q;
        case (db_state_q)
            DB_ARM: begin
                if (key_onehot) begin
                    db_code_d = key;
                    db_cnt_d  = 4'd1;
                    key_dig_d = key_index;
                    if (DB_LIMIT <= 4'd1) begin
                        key_evt_d  = 1'b1;
                        db_state_d = DB_RELEASE;
                    end else begin
                        db_state_d = DB_STABLE;
                    end
                end
            end
            DB_STABLE: begin
                if (key == db_code_q) begin
                    db_cnt_d = db_cnt_q + 4'd1;
                    if (db_cnt_q + 4'd1 >= DB_LIMIT) begin
                        key_evt_d  = 1'b1;
                        db_state_d = DB_RELEASE;
                    end
                end else begin
                    db_state_d = DB_ARM;
                end
            end
            DB_RELEASE: begin
                if (key == 10'd0) db_state_d = DB_ARM;
            end
            default: db_state_d = DB_ARM;
        endcase
    end

    // Shifting in a digit above 5 would push an illegal value into the mod-6 tens counter.
    assign accept = key_evt_q && (cnt_q < 2'd3) && ((cnt_q == 2'd0) || (ones_q <= 4'd5));

    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        cnt_d    = cnt_q;
        loadn_d  = 1'b1;
        locked_d = locked_q;
        if (clear) begin
            state_d  = ST_IDLE;
            min_d    = 4'd0;
            tens_d   = 4'd0;
            ones_d   = 4'd0;
            cnt_d    = 2'd0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_evt_q && !start) begin
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        ones_d  = key_dig_q;
                        cnt_d   = 2'd1;
                        state_d = ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (start) begin
                        loadn_d  = 1'b0;
                        locked_d = 1'b1;
                        state_d  = ST_LOADED;
                    end else if (accept) begin
                        min_d  = tens_q;
                        tens_d = ones_q;
                        ones_d = key_dig_q;
                        cnt_d  = cnt_q + 2'd1;
                    end
                end
                ST_LOADED: begin
                    if (timer_zero && loadn_q) begin
                        state_d  = ST_IDLE;
                        min_d    = 4'd0;
                        tens_d   = 4'd0;
                        ones_d   = 4'd0;
                        cnt_d    = 2'd0;
                        locked_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            db_state_q <= DB_ARM;
            db_cnt_q   <= 4'd0;
            db_code_q  <= 10'd0;
            key_evt_q  <= 1'b0;
            key_dig_q  <= 4'd0;
            state_q    <= ST_IDLE;
            min_q      <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            cnt_q      <= 2'd0;
            loadn_q    <= 1'b1;
            locked_q   <= 1'b0;
        end else begin
            db_state_q <= db_state_d;
            db_cnt_q   <= db_cnt_d;
            db_code_q  <= db_code_d;
            key_evt_q  <= key_evt_d;
            key_dig_q  <= key_dig_d;
            state_q    <= state_d;
            min_q      <= min_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            cnt_q      <= cnt_d;
            loadn_q    <= loadn_d;
            locked_q   <= locked_d;
        end
    end

    assign min_ones  = min_q;
    assign sec_tens  = tens_q;
    assign sec_ones  = ones_q;
    assign loadn     = loadn_q;
    assign digit_cnt = cnt_q;
    assign locked    = locked_q;

endmodule
